// File: rtl/sa_core_ctrl_pkg.sv
// Shared types and helpers for the systolic core controller: FSM encoding,
// a constant-foldable clog2 and flat-vector lane offset helper.
package sa_core_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } sa_state_e;

  function automatic int sa_clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Low bit of element `lane` in a flat vector of `width`-bit elements.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/sa_core_ctrl_if.sv
// Bundle of control, input stream, PE-array and result stream signals.
// slave = the controller, master = host buffers plus PE array.
interface sa_core_ctrl_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int DW   = 8,
  parameter int ACCW = 32,
  parameter int KW   = 9
);
  logic                      start;
  logic [KW-1:0]             cfg_k;
  logic                      busy;
  logic                      done;
  logic                      in_valid;
  logic                      in_ready;
  logic [ROWS*DW-1:0]        in_a;
  logic [COLS*DW-1:0]        in_w;
  logic                      arr_clr;
  logic                      arr_fire;
  logic [ROWS*DW-1:0]        arr_a;
  logic [COLS*DW-1:0]        arr_w;
  logic [ROWS*COLS*ACCW-1:0] arr_res;
  logic                      out_valid;
  logic                      out_ready;
  logic [COLS*ACCW-1:0]      out_data;
  logic                      out_last;

  modport master (
    output start, cfg_k, in_valid, in_a, in_w, arr_res, out_ready,
    input  busy, done, in_ready, arr_clr, arr_fire, arr_a, arr_w,
           out_valid, out_data, out_last
  );

  modport slave (
    input  start, cfg_k, in_valid, in_a, in_w, arr_res, out_ready,
    output busy, done, in_ready, arr_clr, arr_fire, arr_a, arr_w,
           out_valid, out_data, out_last
  );
endinterface

// File: rtl/sa_core_ctrl_skew_buf.sv
// Diagonal skew buffer: lane i is delayed by i shift-enabled cycles,
// lane 0 passes straight through.
module sa_core_ctrl_skew_buf
  import sa_core_ctrl_pkg::*;
#(
  parameter int LANES = 8,
  parameter int DW    = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_shift,
  input  logic [LANES*DW-1:0] i_data,
  output logic [LANES*DW-1:0] o_data
);

  assign o_data[DW-1:0] = i_data[DW-1:0];

  for (genvar gi = 1; gi < LANES; gi++) begin : g_lane
    logic [DW-1:0] r_tap [gi];

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int s = 0; s < gi; s++) r_tap[s] <= '0;
      end else if (i_shift) begin
        r_tap[0] <= i_data[lane_lo(gi, DW) +: DW];
        for (int s = 1; s < gi; s++) r_tap[s] <= r_tap[s-1];
      end
    end

    assign o_data[lane_lo(gi, DW) +: DW] = r_tap[gi-1];
  end

endmodule

// File: rtl/sa_core_ctrl.sv
// Systolic core controller: streams and skews operands into the PE array,
// flushes the wavefront, then drains accumulator rows on a valid/ready stream.
module sa_core_ctrl
  import sa_core_ctrl_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int DW   = 8,
  parameter int ACCW = 32,
  parameter int KMAX = 256
) (
  input  logic          clk,
  input  logic          rstn,
  sa_core_ctrl_if.slave bus
);

  localparam int KW        = sa_clog2(KMAX + 1);
  localparam int FLUSH_CYC = ROWS + COLS - 1;
  localparam int FW        = sa_clog2(FLUSH_CYC + 1);
  localparam int RW        = (ROWS > 1) ? sa_clog2(ROWS) : 1;

  sa_state_e          r_state;
  sa_state_e          w_next;
  logic [KW-1:0]      r_kcfg;
  logic [KW-1:0]      r_kcnt;
  logic [FW-1:0]      r_fcnt;
  logic [RW-1:0]      r_row;
  logic               r_done;

  logic               w_beat;
  logic               w_k_last;
  logic               w_flush_end;
  logic               w_last_row;
  logic               w_out_hs;
  logic               w_accept;
  logic [ROWS*DW-1:0] w_a_in;
  logic [COLS*DW-1:0] w_w_in;

  assign w_accept    = (r_state == ST_IDLE) && bus.start;
  assign w_beat      = (r_state == ST_LOAD) && bus.in_valid;
  assign w_k_last    = ((r_kcnt + KW'(1)) == r_kcfg);
  assign w_flush_end = (r_fcnt == FW'(FLUSH_CYC - 1));
  assign w_last_row  = (r_row == RW'(ROWS - 1));
  assign w_out_hs    = (r_state == ST_DRAIN) && bus.out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_next = (bus.cfg_k == '0) ? ST_FLUSH : ST_LOAD;
      ST_LOAD:  if (w_beat && w_k_last) w_next = ST_FLUSH;
      ST_FLUSH: if (w_flush_end) w_next = ST_DRAIN;
      ST_DRAIN: if (w_out_hs && w_last_row) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = 1'b0;
    bus.arr_clr   = 1'b0;
    bus.arr_fire  = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      ST_IDLE:  bus.arr_clr = bus.start;
      ST_LOAD: begin
        bus.busy     = 1'b1;
        bus.in_ready = 1'b1;
        bus.arr_fire = bus.in_valid;
      end
      ST_FLUSH: begin
        bus.busy     = 1'b1;
        bus.arr_fire = 1'b1;
      end
      ST_DRAIN: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_kcfg <= '0;
      r_kcnt <= '0;
      r_fcnt <= '0;
      r_row  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_out_hs && w_last_row;
      if (w_accept) begin
        r_kcfg <= bus.cfg_k;
        r_kcnt <= '0;
      end else if (w_beat) begin
        r_kcnt <= r_kcnt + KW'(1);
      end
      if (r_state == ST_FLUSH) r_fcnt <= w_flush_end ? '0 : r_fcnt + FW'(1);
      if (w_out_hs) r_row <= w_last_row ? '0 : r_row + RW'(1);
    end
  end

  assign bus.done = r_done;

  // Non-beat cycles feed zeros, which is also what flushes the wavefront.
  assign w_a_in = w_beat ? bus.in_a : '0;
  assign w_w_in = w_beat ? bus.in_w : '0;

  sa_core_ctrl_skew_buf #(.LANES(ROWS), .DW(DW)) u_skew_a (
    .clk     (clk),
    .rstn    (rstn),
    .i_shift (bus.arr_fire),
    .i_data  (w_a_in),
    .o_data  (bus.arr_a)
  );

  sa_core_ctrl_skew_buf #(.LANES(COLS), .DW(DW)) u_skew_w (
    .clk     (clk),
    .rstn    (rstn),
    .i_shift (bus.arr_fire),
    .i_data  (w_w_in),
    .o_data  (bus.arr_w)
  );

  // The array holds while draining, so the row mux is stable under backpressure.
  always_comb begin
    bus.out_data = '0;
    bus.out_last = 1'b0;
    if (r_state == ST_DRAIN) begin
      bus.out_data = bus.arr_res[lane_lo(int'(r_row), COLS*ACCW) +: COLS*ACCW];
      bus.out_last = w_last_row;
    end
  end

endmodule

// File: tb/tb_sa_core_ctrl.sv
// Bench for sa_core_ctrl: drives jobs into a 4x4 instance with an output-
// stationary PE array model and checks drained rows against a matrix product.
module tb_sa_core_ctrl;
  localparam int R         = 4;
  localparam int C         = 4;
  localparam int DW        = 8;
  localparam int ACCW      = 32;
  localparam int KMAX      = 16;
  localparam int KW        = 5;
  localparam int FLUSH_CYC = R + C - 1;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sa_core_ctrl_if #(.ROWS(R), .COLS(C), .DW(DW), .ACCW(ACCW), .KW(KW)) bus ();

  sa_core_ctrl #(.ROWS(R), .COLS(C), .DW(DW), .ACCW(ACCW), .KMAX(KMAX)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // PE array: a moves right, w moves down, each PE accumulates a*w on fire.
  logic [ACCW-1:0]       pe_acc [R][C];
  logic [DW-1:0]         pe_a   [R][C];
  logic [DW-1:0]         pe_w   [R][C];
  logic [R*C*ACCW-1:0]   w_res;

  always @(posedge clk) begin : pe_model
    logic [DW-1:0] ain, win;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        ain = (c == 0) ? bus.arr_a[r*DW +: DW] : pe_a[r][c-1];
        win = (r == 0) ? bus.arr_w[c*DW +: DW] : pe_w[r-1][c];
        if (bus.arr_clr) begin
          pe_acc[r][c] <= '0;
          pe_a[r][c]   <= '0;
          pe_w[r][c]   <= '0;
        end else if (bus.arr_fire) begin
          pe_acc[r][c] <= pe_acc[r][c] + ACCW'(ain) * ACCW'(win);
          pe_a[r][c]   <= ain;
          pe_w[r][c]   <= win;
        end
      end
  end

  always_comb begin
    w_res = '0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        w_res[(r*C+c)*ACCW +: ACCW] = pe_acc[r][c];
  end
  assign bus.arr_res = w_res;

  // Fire-cycle monitor: counts fires and checks the diagonal skew of a single beat
  // whose lane values are lane index + 1.
  int fire_cnt;
  int skew_bad;
  bit mon_en = 1'b0;
  always @(negedge clk) begin : fire_mon
    logic [DW-1:0] ex;
    if (mon_en && bus.arr_fire) begin
      for (int i = 0; i < R; i++) begin
        ex = (fire_cnt == i) ? DW'(i + 1) : '0;
        if (bus.arr_a[i*DW +: DW] !== ex) skew_bad++;
      end
      for (int j = 0; j < C; j++) begin
        ex = (fire_cnt == j) ? DW'(j + 1) : '0;
        if (bus.arr_w[j*DW +: DW] !== ex) skew_bad++;
      end
      fire_cnt++;
    end
  end

  int unsigned     ja [KMAX][R];
  int unsigned     jw [KMAX][C];
  logic [ACCW-1:0] got [R][C];
  bit gaps, stall, poke, tmo;
  bit clr_seen, busy_mid, done_ok, done_after, busy_after;
  int lat, last_mask, stable_bad, poke_bad;

  function automatic logic [ACCW-1:0] ref_dot(input int r, input int c, input int k);
    logic [ACCW-1:0] s;
    s = '0;
    for (int b = 0; b < k; b++) s += ACCW'(ja[b][r] * jw[b][c]);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int b = 0; b < KMAX; b++) begin
      for (int i = 0; i < R; i++) ja[b][i] = $urandom_range(0, 255);
      for (int j = 0; j < C; j++) jw[b][j] = $urandom_range(0, 255);
    end
  endtask

  task automatic fill_zero();
    for (int b = 0; b < KMAX; b++) begin
      for (int i = 0; i < R; i++) ja[b][i] = 0;
      for (int j = 0; j < C; j++) jw[b][j] = 0;
    end
  endtask

  task automatic run_job(input int k);
    int b, cyc;
    logic acc;
    logic [C*ACCW-1:0] snap;
    tmo = 0; stable_bad = 0; poke_bad = 0; last_mask = 0; lat = -1;
    fire_cnt = 0; mon_en = 1'b1;
    bus.start = 1'b1;
    bus.cfg_k = KW'(k);
    #1 clr_seen = bus.arr_clr;
    tick();
    bus.start = 1'b0;
    busy_mid  = bus.busy;
    b = 0; cyc = 0;
    while (b < k && cyc < 2000) begin
      bus.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      for (int i = 0; i < R; i++)
        bus.in_a[i*DW +: DW] = bus.in_valid ? DW'(ja[b][i]) : DW'($urandom);
      for (int j = 0; j < C; j++)
        bus.in_w[j*DW +: DW] = bus.in_valid ? DW'(jw[b][j]) : DW'($urandom);
      #1 acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) b++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    if (b < k) tmo = 1;
    cyc = 0;
    while (!bus.out_valid && cyc < 200) begin
      if (poke) begin
        bus.start = 1'b1; bus.cfg_k = KW'(3); bus.in_valid = 1'b1;
        #1 if (bus.arr_clr || bus.in_ready) poke_bad++;
      end
      tick();
      cyc++;
    end
    bus.start = 1'b0; bus.in_valid = 1'b0;
    lat = cyc;
    if (!bus.out_valid) tmo = 1;
    for (int r = 0; r < R && !tmo; r++) begin
      bus.out_ready = 1'b0;
      if (stall) begin
        snap = bus.out_data;
        for (int s = 0; s < 3; s++) begin
          tick();
          if (bus.out_data !== snap || bus.out_valid !== 1'b1) stable_bad++;
        end
      end
      bus.out_ready = 1'b1;
      #1;
      if (!bus.out_valid) tmo = 1;
      for (int c = 0; c < C; c++) got[r][c] = bus.out_data[c*ACCW +: ACCW];
      if (bus.out_last) last_mask |= (1 << r);
      tick();
    end
    bus.out_ready = 1'b0;
    done_ok    = bus.done;
    busy_after = bus.busy;
    tick();
    done_after = bus.done || bus.busy;
    mon_en = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    checks++;
    if ({bus.busy, bus.done, bus.arr_clr, bus.arr_fire, bus.in_ready, bus.out_valid, bus.out_last} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0", {bus.busy, bus.done, bus.arr_clr, bus.arr_fire, bus.in_ready, bus.out_valid, bus.out_last});
    end
    checks++;
    if (bus.arr_a !== '0 || bus.arr_w !== '0) begin
      errors++;
      $display("FAIL reset_arr: got a=%h w=%h expected 0", bus.arr_a, bus.arr_w);
    end
    checks++;
    if (bus.out_data !== '0) begin
      errors++;
      $display("FAIL reset_out_data: got %h expected 0", bus.out_data);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    fill_zero();
    ja[0][0] = 1; ja[0][1] = 3; ja[1][0] = 2; ja[1][1] = 4;
    jw[0][0] = 5; jw[0][1] = 6; jw[1][0] = 7; jw[1][1] = 8;
    gaps = 0; stall = 0; poke = 0;
    run_job(2);
    checks++;
    if (tmo !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %0d expected 0", tmo); end
    checks++;
    if ({clr_seen, busy_mid} !== 2'b11) begin errors++; $display("FAIL basic_clr_busy: got %b expected 11", {clr_seen, busy_mid}); end
    checks++;
    if ({got[0][0], got[0][1], got[1][0], got[1][1]} !== {32'd19, 32'd22, 32'd43, 32'd50}) begin
      errors++;
      $display("FAIL basic_2x2: got %0d %0d %0d %0d expected 19 22 43 50", got[0][0], got[0][1], got[1][0], got[1][1]);
    end
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        checks++;
        if (got[r][c] !== ref_dot(r, c, 2)) begin
          errors++;
          $display("FAIL basic_res[%0d][%0d]: got %0d expected %0d", r, c, got[r][c], ref_dot(r, c, 2));
        end
      end
    checks++;
    if (last_mask !== (1 << (R-1))) begin errors++; $display("FAIL basic_last: got %b expected %b", last_mask, 1 << (R-1)); end
    checks++;
    if ({done_ok, busy_after, done_after} !== 3'b100) begin
      errors++;
      $display("FAIL basic_done: got %b expected 100", {done_ok, busy_after, done_after});
    end
    checks++;
    if (lat !== FLUSH_CYC) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, FLUSH_CYC); end
    checks++;
    if (fire_cnt !== 2 + FLUSH_CYC) begin errors++; $display("FAIL basic_fires: got %0d expected %0d", fire_cnt, 2 + FLUSH_CYC); end
  endtask

  task automatic test_skew();
    fill_zero();
    for (int i = 0; i < R; i++) ja[0][i] = i + 1;
    for (int j = 0; j < C; j++) jw[0][j] = j + 1;
    gaps = 0; stall = 0; poke = 0;
    skew_bad = 0;
    run_job(1);
    checks++;
    if (skew_bad !== 0) begin errors++; $display("FAIL skew_diag: got %0d bad lanes expected 0", skew_bad); end
    checks++;
    if (fire_cnt !== 1 + FLUSH_CYC) begin errors++; $display("FAIL skew_fires: got %0d expected %0d", fire_cnt, 1 + FLUSH_CYC); end
    checks++;
    if (got[R-1][C-1] !== ACCW'(R * C)) begin errors++; $display("FAIL skew_corner: got %0d expected %0d", got[R-1][C-1], R * C); end
  endtask

  task automatic test_stalls();
    logic [ACCW-1:0] base [R][C];
    int k;
    for (int it = 0; it < 3; it++) begin
      k = $urandom_range(3, KMAX);
      fill_random();
      gaps = 0; stall = 0; poke = 0;
      run_job(k);
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) begin
          base[r][c] = got[r][c];
          checks++;
          if (got[r][c] !== ref_dot(r, c, k)) begin
            errors++;
            $display("FAIL nogap_res[%0d][%0d] k=%0d: got %0d expected %0d", r, c, k, got[r][c], ref_dot(r, c, k));
          end
        end
      gaps = 1; stall = 1;
      run_job(k);
      checks++;
      if (tmo !== 1'b0) begin errors++; $display("FAIL stall_timeout: got %0d expected 0", tmo); end
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) begin
          checks++;
          if (got[r][c] !== base[r][c]) begin
            errors++;
            $display("FAIL stall_res[%0d][%0d]: got %0d expected %0d", r, c, got[r][c], base[r][c]);
          end
        end
      checks++;
      if (stable_bad !== 0) begin errors++; $display("FAIL stall_stable: got %0d changes expected 0", stable_bad); end
      checks++;
      if (fire_cnt !== k + FLUSH_CYC) begin errors++; $display("FAIL stall_fires: got %0d expected %0d", fire_cnt, k + FLUSH_CYC); end
      checks++;
      if (done_ok !== 1'b1) begin errors++; $display("FAIL stall_done: got %0d expected 1", done_ok); end
    end
  endtask

  task automatic test_zero_k();
    fill_random();
    gaps = 0; stall = 0; poke = 1;
    run_job(0);
    poke = 0;
    checks++;
    if (clr_seen !== 1'b1) begin errors++; $display("FAIL zk_clr: got %0d expected 1", clr_seen); end
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        checks++;
        if (got[r][c] !== '0) begin errors++; $display("FAIL zk_res[%0d][%0d]: got %0d expected 0", r, c, got[r][c]); end
      end
    checks++;
    if (poke_bad !== 0) begin errors++; $display("FAIL zk_start_ignored: got %0d expected 0", poke_bad); end
    checks++;
    if (fire_cnt !== FLUSH_CYC) begin errors++; $display("FAIL zk_fires: got %0d expected %0d", fire_cnt, FLUSH_CYC); end
    checks++;
    if ({done_ok, busy_after, done_after, last_mask[R-1]} !== 4'b1001) begin
      errors++;
      $display("FAIL zk_done: got %b expected 1001", {done_ok, busy_after, done_after, last_mask[R-1]});
    end
  endtask

  task automatic test_reset_mid();
    fill_random();
    bus.start = 1'b1; bus.cfg_k = KW'(4);
    tick();
    bus.start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.in_valid = 1'b1;
      for (int i = 0; i < R; i++) bus.in_a[i*DW +: DW] = DW'(ja[b][i]);
      for (int j = 0; j < C; j++) bus.in_w[j*DW +: DW] = DW'(jw[b][j]);
      tick();
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.arr_clr, bus.arr_fire, bus.in_ready, bus.out_valid, bus.out_last} !== 7'b0) begin
      errors++;
      $display("FAIL midrst_ctrl: got %b expected 0", {bus.busy, bus.done, bus.arr_clr, bus.arr_fire, bus.in_ready, bus.out_valid, bus.out_last});
    end
    checks++;
    if (bus.arr_a !== '0 || bus.arr_w !== '0 || bus.out_data !== '0) begin
      errors++;
      $display("FAIL midrst_data: got a=%h w=%h out=%h expected 0", bus.arr_a, bus.arr_w, bus.out_data);
    end
    bus.in_valid = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    checks++;
    if ({bus.done, bus.busy} !== 2'b00) begin errors++; $display("FAIL midrst_no_done: got %b expected 00", {bus.done, bus.busy}); end
    fill_zero();
    for (int i = 0; i < R; i++) ja[0][i] = 1;
    for (int j = 0; j < C; j++) jw[0][j] = 1;
    gaps = 0; stall = 0; poke = 0;
    run_job(1);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        checks++;
        if (got[r][c] !== ACCW'(1)) begin errors++; $display("FAIL midrst_res[%0d][%0d]: got %0d expected 1", r, c, got[r][c]); end
      end
  endtask

  initial begin
    bus.start = 1'b0; bus.cfg_k = '0; bus.in_valid = 1'b0;
    bus.in_a = '0; bus.in_w = '0; bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_skew();
    test_stalls();
    test_zero_k();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
